// File: rtl/ltc_frame_sync_ctrl.sv
// LTC frame synchroniser: hunts for the 16-bit sync word in the recovered bit
// stream, confirms lock, flywheels through sync errors and emits 64-bit payloads.
module ltc_frame_sync_ctrl #(
    parameter logic [15:0] SYNC_WORD      = 16'h3FFD,
    parameter int unsigned LOCK_CONFIRM   = 2,
    parameter int unsigned MISS_LIMIT     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_valid,
    input  logic        bit_data,
    input  logic        nosignal,
    output logic        frame_valid,
    output logic [63:0] frame_data,
    output logic        locked,
    output logic [1:0]  state,
    output logic [15:0] frame_count,
    output logic [7:0]  sync_err_count
);
    localparam int unsigned   TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]    LOCK_CONFIRM_C = LOCK_CONFIRM[3:0];
    localparam logic [3:0]    MISS_LIMIT_C   = MISS_LIMIT[3:0];
    localparam logic [TW-1:0] TIMEOUT_C      = TIMEOUT_CYCLES[TW-1:0];
    localparam logic [6:0]    LAST_BIT       = 7'd79;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [79:0]   sr_q, sr_d;
    logic [6:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]    confirm_cnt_q, confirm_cnt_d;
    logic [3:0]    miss_cnt_q, miss_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          emit_pend_q, emit_pend_d;
    logic          frame_valid_q, frame_valid_d;
    logic [63:0]   frame_data_q, frame_data_d;
    logic          locked_q, locked_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic [7:0]    sync_err_count_q, sync_err_count_d;

    logic [79:0]   sr_shift;
    logic          sync_hit;
    logic          boundary;

    always_comb begin
        state_d          = state_q;
        sr_d             = sr_q;
        bit_cnt_d        = bit_cnt_q;
        confirm_cnt_d    = confirm_cnt_q;
        miss_cnt_d       = miss_cnt_q;
        emit_pend_d      = 1'b0;
        frame_valid_d    = 1'b0;
        frame_data_d     = frame_data_q;
        frame_count_d    = frame_count_q;
        sync_err_count_d = sync_err_count_q;

        sr_shift = {sr_q[78:0], bit_data};
        sync_hit = (sr_shift[15:0] == SYNC_WORD);
        boundary = (bit_cnt_q == LAST_BIT);

        // The frame captured on the previous edge is published one cycle later.
        if (emit_pend_q) begin
            frame_valid_d = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            for (int i = 0; i < 64; i++) begin
                frame_data_d[i] = sr_q[79 - i];
            end
        end

        if (bit_valid) begin
            timer_d = '0;
        end else if (timer_q != TIMEOUT_C) begin
            timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            timer_d = timer_q;
        end

        if (nosignal || (!bit_valid && timer_d == TIMEOUT_C)) begin
            state_d       = HUNT;
            bit_cnt_d     = '0;
            confirm_cnt_d = '0;
            miss_cnt_d    = '0;
        end else if (bit_valid) begin
            sr_d      = sr_shift;
            bit_cnt_d = boundary ? 7'd0 : bit_cnt_q + 7'd1;
            case (state_q)
                HUNT: begin
                    if (sync_hit) begin
                        bit_cnt_d     = '0;
                        confirm_cnt_d = 4'd1;
                        miss_cnt_d    = '0;
                        state_d       = (LOCK_CONFIRM_C == 4'd1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (boundary) begin
                        if (sync_hit) begin
                            confirm_cnt_d = confirm_cnt_q + 4'd1;
                            if (confirm_cnt_d == LOCK_CONFIRM_C) begin
                                state_d     = LOCKED;
                                miss_cnt_d  = '0;
                                emit_pend_d = 1'b1;
                            end
                        end else begin
                            state_d       = HUNT;
                            confirm_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Mid-frame matches are ignored; only the flywheel boundary counts.
                    if (boundary) begin
                        if (sync_hit) begin
                            emit_pend_d = 1'b1;
                            miss_cnt_d  = '0;
                        end else begin
                            if (sync_err_count_q != 8'hFF) begin
                                sync_err_count_d = sync_err_count_q + 8'd1;
                            end
                            miss_cnt_d = miss_cnt_q + 4'd1;
                            if (miss_cnt_d == MISS_LIMIT_C) begin
                                state_d       = HUNT;
                                confirm_cnt_d = '0;
                                miss_cnt_d    = '0;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= HUNT;
            sr_q             <= '0;
            bit_cnt_q        <= '0;
            confirm_cnt_q    <= '0;
            miss_cnt_q       <= '0;
            timer_q          <= '0;
            emit_pend_q      <= 1'b0;
            frame_valid_q    <= 1'b0;
            frame_data_q     <= '0;
            locked_q         <= 1'b0;
            frame_count_q    <= '0;
            sync_err_count_q <= '0;
        end else begin
            state_q          <= state_d;
            sr_q             <= sr_d;
            bit_cnt_q        <= bit_cnt_d;
            confirm_cnt_q    <= confirm_cnt_d;
            miss_cnt_q       <= miss_cnt_d;
            timer_q          <= timer_d;
            emit_pend_q      <= emit_pend_d;
            frame_valid_q    <= frame_valid_d;
            frame_data_q     <= frame_data_d;
            locked_q         <= locked_d;
            frame_count_q    <= frame_count_d;
            sync_err_count_q <= sync_err_count_d;
        end
    end

    assign frame_valid    = frame_valid_q;
    assign frame_data     = frame_data_q;
    assign locked         = locked_q;
    assign state          = state_q;
    assign frame_count    = frame_count_q;
    assign sync_err_count = sync_err_count_q;

endmodule

// File: tb/tb_ltc_frame_sync_ctrl.sv
// Self-checking bench for ltc_frame_sync_ctrl: randomized bit timing and payloads
// compared against a bit-history reference model of the frame-sync rules.
module tb_ltc_frame_sync_ctrl;
    localparam logic [15:0] SYNC = 16'h3FFD;
    localparam logic [15:0] BAD  = 16'h3FFC;
    localparam logic [63:0] PAY  = 64'h0123_4567_89AB_CDEF;
    localparam int LC = 2;
    localparam int ML = 3;
    localparam int TO = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_data = 1'b0;
    logic        nosignal = 1'b0;
    logic        frame_valid;
    logic [63:0] frame_data;
    logic        locked;
    logic [1:0]  state;
    logic [15:0] frame_count;
    logic [7:0]  sync_err_count;

    int errors = 0;
    int checks = 0;
    int obs_pulses = 0;
    logic [63:0] obs_data = '0;

    // Reference model: last 80 accepted bits, frame alignment as a bit index.
    bit          m_hist[$];
    int          m_state;
    longint      m_nbits, m_anchor;
    int          m_good, m_miss, m_idle;
    bit          m_pend = 1'b0;
    logic [63:0] m_pend_data, m_data;
    logic [15:0] m_frames;
    logic [7:0]  m_errs;
    int          m_pulses = 0;

    ltc_frame_sync_ctrl #(
        .SYNC_WORD(SYNC), .LOCK_CONFIRM(LC), .MISS_LIMIT(ML), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_data(bit_data),
        .nosignal(nosignal), .frame_valid(frame_valid), .frame_data(frame_data),
        .locked(locked), .state(state), .frame_count(frame_count),
        .sync_err_count(sync_err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hist_sync();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15 - i] = m_hist[64 + i];
        return w;
    endfunction

    function automatic logic [63:0] hist_payload();
        logic [63:0] p;
        for (int i = 0; i < 64; i++) p[i] = m_hist[i];
        return p;
    endfunction

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < 80; i++) m_hist.push_back(1'b0);
        m_state = 0; m_nbits = 0; m_anchor = 0;
        m_good = 0; m_miss = 0; m_idle = 0;
        m_pend = 1'b0; m_data = '0; m_frames = '0; m_errs = '0;
    endfunction

    function automatic void model_hunt();
        m_state = 0; m_good = 0; m_miss = 0;
    endfunction

    function automatic void model_cycle(bit r, bit bv, bit bd, bit ns);
        bit match;
        if (r) begin
            model_reset();
            return;
        end
        if (m_pend) begin
            m_pend = 1'b0;
            m_frames = m_frames + 16'd1;
            m_data = m_pend_data;
            m_pulses++;
        end
        m_idle = bv ? 0 : ((m_idle < TO) ? m_idle + 1 : m_idle);
        if (ns) begin
            model_hunt();
            return;
        end
        if (!bv) begin
            if (m_idle >= TO) model_hunt();
            return;
        end
        m_hist.push_back(bd);
        void'(m_hist.pop_front());
        m_nbits++;
        match = (hist_sync() == SYNC);
        if (m_state == 0) begin
            if (match) begin
                m_anchor = m_nbits; m_good = 1; m_miss = 0;
                m_state = (LC == 1) ? 2 : 1;
            end
        end else if (((m_nbits - m_anchor) % 80) == 0) begin
            if (m_state == 1) begin
                if (match) begin
                    m_good++;
                    if (m_good >= LC) begin
                        m_state = 2; m_miss = 0;
                        m_pend = 1'b1; m_pend_data = hist_payload();
                    end
                end else begin
                    model_hunt();
                end
            end else if (match) begin
                m_pend = 1'b1; m_pend_data = hist_payload(); m_miss = 0;
            end else begin
                if (m_errs != 8'hFF) m_errs = m_errs + 8'd1;
                m_miss++;
                if (m_miss >= ML) model_hunt();
            end
        end
    endfunction

    task automatic tick(input bit r, input bit bv, input bit bd, input bit ns);
        rst = r; bit_valid = bv; bit_data = bd; nosignal = ns;
        @(posedge clk);
        #1;
        model_cycle(r, bv, bd, ns);
        if (frame_valid === 1'b1) begin
            obs_pulses++;
            obs_data = frame_data;
        end
        rst = 1'b0; bit_valid = 1'b0; bit_data = 1'b0; nosignal = 1'b0;
    endtask

    task automatic send_bit(input bit b, input int gap);
        tick(1'b0, 1'b1, b, 1'b0);
        repeat (gap) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Ends right after the capture edge of bit 79 (no trailing idle cycle).
    task automatic send_frame(input logic [63:0] p, input logic [15:0] s, input int max_gap);
        for (int i = 0; i < 80; i++) begin
            send_bit((i < 64) ? p[i] : s[79 - i], (i == 79) ? 0 : int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic relock();
        send_frame(PAY, SYNC, 2);
        send_frame(PAY, SYNC, 2);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (state !== 2'b10 || state !== 2'(m_state)) begin errors++; $display("[TB] FAIL relock_state: got %0d, want 2 (model %0d)", state, m_state); end
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (state !== 2'b00) begin errors++; $display("[TB] FAIL reset_state: got %0d, want 0", state); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b, want 0", locked); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_valid: got %b, want 0", frame_valid); end
        checks++; if (frame_data !== 64'd0) begin errors++; $display("[TB] FAIL reset_frame_data: got %h, want 0", frame_data); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_count: got %0d, want 0", frame_count); end
        checks++; if (sync_err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_sync_err: got %0d, want 0", sync_err_count); end
    endtask

    task automatic test_clean_frames();
        int p0;
        p0 = obs_pulses;
        send_frame(PAY, SYNC, 2);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (state !== 2'b01) begin errors++; $display("[TB] FAIL clean_verify: got %0d, want 1", state); end
        send_frame(PAY, SYNC, 2);
        checks++; if (state !== 2'b10 || locked !== 1'b1) begin errors++; $display("[TB] FAIL clean_lock: got state %0d locked %b, want 2/1", state, locked); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL clean_latency: got frame_valid %b in capture cycle, want 0", frame_valid); end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL clean_pulse: got %b, want 1", frame_valid); end
        checks++; if (frame_data !== PAY) begin errors++; $display("[TB] FAIL clean_data: got %h, want %h", frame_data, PAY); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("[TB] FAIL clean_count1: got %0d, want 1", frame_count); end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_valid !== 1'b0 || frame_data !== PAY) begin errors++; $display("[TB] FAIL clean_hold: got valid %b data %h, want 0/%h", frame_valid, frame_data, PAY); end
        send_frame(PAY, SYNC, 2);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_count !== 16'd2) begin errors++; $display("[TB] FAIL clean_count2: got %0d, want 2", frame_count); end
        checks++; if (obs_pulses - p0 != 2) begin errors++; $display("[TB] FAIL clean_pulses: got %0d, want 2", obs_pulses - p0); end
    endtask

    task automatic test_hunt_junk();
        int p0, mp0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        p0 = obs_pulses; mp0 = m_pulses;
        // A forced zero every 8 bits keeps the junk from forming a sync word.
        for (int i = 0; i < 37; i++) send_bit((i % 8 == 7) ? 1'b0 : 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        checks++; if (state !== 2'b00) begin errors++; $display("[TB] FAIL junk_hunt: got %0d, want 0", state); end
        for (int f = 0; f < 4; f++) begin
            send_frame(PAY, SYNC, 2);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            checks++; if (state !== 2'(m_state)) begin errors++; $display("[TB] FAIL junk_state_f%0d: got %0d, want %0d", f, state, m_state); end
        end
        checks++; if (obs_pulses - p0 != 3 || obs_pulses - p0 != m_pulses - mp0) begin errors++; $display("[TB] FAIL junk_pulses: got %0d, want 3 (model %0d)", obs_pulses - p0, m_pulses - mp0); end
        checks++; if (frame_count !== m_frames) begin errors++; $display("[TB] FAIL junk_count: got %0d, want %0d", frame_count, m_frames); end
    endtask

    task automatic test_sync_errors();
        int p0;
        logic [63:0] pay;
        p0 = obs_pulses;
        send_frame({$urandom, $urandom}, BAD, 2);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (obs_pulses != p0) begin errors++; $display("[TB] FAIL err_nopulse: got %0d pulses, want 0", obs_pulses - p0); end
        checks++; if (sync_err_count !== 8'd1 || sync_err_count !== m_errs) begin errors++; $display("[TB] FAIL err_count1: got %0d, want 1", sync_err_count); end
        checks++; if (state !== 2'b10) begin errors++; $display("[TB] FAIL err_flywheel: got %0d, want 2", state); end
        pay = {$urandom, $urandom};
        send_frame(pay, SYNC, 2);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (obs_pulses - p0 != 1 || frame_data !== pay) begin errors++; $display("[TB] FAIL err_recover: got %0d pulses data %h, want 1/%h", obs_pulses - p0, frame_data, pay); end
        for (int f = 0; f < 3; f++) begin
            send_frame({$urandom, $urandom}, BAD, 2);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            checks++; if (state !== ((f == 2) ? 2'b00 : 2'b10) || state !== 2'(m_state)) begin errors++; $display("[TB] FAIL err_miss%0d: got state %0d, want %0d", f, state, (f == 2) ? 0 : 2); end
        end
        checks++; if (sync_err_count !== 8'd4 || sync_err_count !== m_errs) begin errors++; $display("[TB] FAIL err_count4: got %0d, want 4", sync_err_count); end
    endtask

    task automatic test_timeout();
        logic [63:0] pay;
        pay = PAY;
        relock();
        repeat (TO - 2) tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (state !== 2'b10) begin errors++; $display("[TB] FAIL timeout_early: got %0d, want 2", state); end
        send_bit(pay[0], 0);
        checks++; if (state !== 2'b10 || state !== 2'(m_state)) begin errors++; $display("[TB] FAIL timeout_bit_saves: got %0d, want 2", state); end
        repeat (TO - 1) tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (state !== 2'b10) begin errors++; $display("[TB] FAIL timeout_1999: got %0d, want 2", state); end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (state !== 2'b00 || locked !== 1'b0 || state !== 2'(m_state)) begin errors++; $display("[TB] FAIL timeout_2000: got state %0d locked %b, want 0/0", state, locked); end
    endtask

    task automatic test_nosignal();
        int p0;
        logic [63:0] pay;
        logic [15:0] s;
        pay = PAY; s = SYNC;
        relock();
        p0 = obs_pulses;
        for (int i = 0; i < 79; i++) send_bit((i < 64) ? pay[i] : s[79 - i], int'($urandom_range(0, 2)));
        tick(1'b0, 1'b1, s[0], 1'b1);
        checks++; if (state !== 2'b00 || locked !== 1'b0) begin errors++; $display("[TB] FAIL nosig_hunt: got state %0d locked %b, want 0/0", state, locked); end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_valid !== 1'b0 || obs_pulses != p0) begin errors++; $display("[TB] FAIL nosig_nopulse: got %0d pulses, want 0", obs_pulses - p0); end
        checks++; if (state !== 2'(m_state)) begin errors++; $display("[TB] FAIL nosig_model: got %0d, want %0d", state, m_state); end
    endtask

    task automatic test_back_to_back();
        int p0, mp0;
        p0 = obs_pulses; mp0 = m_pulses;
        for (int f = 0; f < 4; f++) begin
            send_frame({$urandom, $urandom}, SYNC, 0);
            checks++; if (state !== 2'(m_state)) begin errors++; $display("[TB] FAIL b2b_state_f%0d: got %0d, want %0d", f, state, m_state); end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (obs_pulses - p0 != m_pulses - mp0) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d, want %0d", obs_pulses - p0, m_pulses - mp0); end
        checks++; if (obs_data !== m_data || frame_data !== m_data) begin errors++; $display("[TB] FAIL b2b_data: got %h, want %h", frame_data, m_data); end
        checks++; if (frame_count !== m_frames) begin errors++; $display("[TB] FAIL b2b_count: got %0d, want %0d", frame_count, m_frames); end
    endtask

    task automatic test_reset_midframe();
        relock();
        for (int i = 0; i < 30; i++) send_bit(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (state !== 2'b00 || locked !== 1'b0 || frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ctrl: got state %0d locked %b valid %b, want 0/0/0", state, locked, frame_valid); end
        checks++; if (frame_data !== 64'd0 || frame_count !== 16'd0 || sync_err_count !== 8'd0) begin errors++; $display("[TB] FAIL rstmid_data: got %h/%0d/%0d, want zeros", frame_data, frame_count, sync_err_count); end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_after: got %b, want 0", frame_valid); end
        send_frame(PAY, SYNC, 2);
        send_frame(PAY, SYNC, 2);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_count !== 16'd1 || frame_count !== m_frames) begin errors++; $display("[TB] FAIL rstmid_count: got %0d, want 1", frame_count); end
        checks++; if (state !== 2'b10 || frame_data !== PAY) begin errors++; $display("[TB] FAIL rstmid_relock: got state %0d data %h, want 2/%h", state, frame_data, PAY); end
    endtask

    initial begin
        $display("[TB] ltc_frame_sync_ctrl bench start");
        test_reset();
        test_clean_frames();
        test_hunt_junk();
        test_sync_errors();
        test_timeout();
        test_nosignal();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
